// File: rtl/array_slice_accumulator_if.sv
// Operand/product handshake plus the row-stage drive and return signals, in one bundle.
// The slave side is the accumulator; the master side is the operand source, the consumer and the row stage.
interface array_slice_accumulator_if #(
  parameter int A_WIDTH = 8,
  parameter int P_WIDTH = A_WIDTH + 8
);
  logic               in_valid;
  logic               in_ready;
  logic [A_WIDTH-1:0] in_a;
  logic [7:0]         in_b;
  logic [1:0]         row_a;
  logic [7:0]         row_b;
  logic [7:0]         row_s;
  logic               row_c;
  logic               out_valid;
  logic               out_ready;
  logic [P_WIDTH-1:0] out_p;
  logic               busy;

  modport slave (
    input  in_valid, in_a, in_b, row_s, row_c, out_ready,
    output in_ready, row_a, row_b, out_valid, out_p, busy
  );

  modport master (
    output in_valid, in_a, in_b, row_s, row_c, out_ready,
    input  in_ready, row_a, row_b, out_valid, out_p, busy
  );
endinterface

// File: rtl/array_slice_accumulator.sv
// Steps A through a 2x8 row stage two bits per clock and accumulates the shifted row results into A*B.
// Latency A_WIDTH/2 cycles from accept to out_valid; the product is held until out_ready, and no operands are taken meanwhile.
module array_slice_accumulator #(
  parameter int A_WIDTH = 8,
  parameter int P_WIDTH = A_WIDTH + 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  array_slice_accumulator_if.slave bus
);
  localparam int SLICES = A_WIDTH / 2;
  localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [A_WIDTH-1:0] a_sh;
  logic [7:0]         b_reg;
  logic [P_WIDTH-1:0] acc;
  logic [IDX_W-1:0]   idx;

  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;
  logic [1:0]         row_a_q;
  logic [7:0]         row_b_q;
  logic [P_WIDTH-1:0] out_p_q;

  logic [9:0]         slice_v;
  logic [A_WIDTH-1:0] a_nxt;
  logic [P_WIDTH-1:0] acc_nxt;

  // The row stage omits bit 0 of the slice product, so it is rebuilt here.
  assign slice_v = {bus.row_c, bus.row_s, a_sh[0] & b_reg[0]};
  assign a_nxt   = a_sh >> 2;
  assign acc_nxt = acc + (P_WIDTH'(slice_v) << (2 * idx));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_reg       <= '0;
      acc         <= '0;
      idx         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      row_a_q     <= '0;
      row_b_q     <= '0;
      out_p_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh       <= bus.in_a;
            b_reg      <= bus.in_b;
            acc        <= '0;
            idx        <= '0;
            state      <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            row_a_q    <= bus.in_a[1:0];
            row_b_q    <= bus.in_b;
          end
        end
        RUN: begin
          acc     <= acc_nxt;
          a_sh    <= a_nxt;
          idx     <= idx + 1'b1;
          row_a_q <= a_nxt[1:0];
          if (idx == LAST_IDX) begin
            state       <= DONE;
            row_a_q     <= '0;
            row_b_q     <= '0;
            out_valid_q <= 1'b1;
            out_p_q     <= acc_nxt;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.row_a     = row_a_q;
  assign bus.row_b     = row_b_q;
  assign bus.out_p     = out_p_q;
endmodule

// File: tb/tb_array_slice_accumulator.sv
// Bench for array_slice_accumulator: a golden 2x8 row stage plus directed and random products checked against a*b.
module tb_array_slice_accumulator;
  localparam int A_WIDTH = 8;
  localparam int P_WIDTH = A_WIDTH + 8;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;

  array_slice_accumulator_if #(.A_WIDTH(A_WIDTH), .P_WIDTH(P_WIDTH)) bus ();

  array_slice_accumulator #(.A_WIDTH(A_WIDTH), .P_WIDTH(P_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Golden combinational row: {c,s} is the 2x8 product without its bit 0.
  logic [9:0] row_prod;
  assign row_prod   = 10'(bus.row_a) * 10'(bus.row_b);
  assign bus.row_s  = row_prod[8:1];
  assign bus.row_c  = row_prod[9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_p !== '0) begin failures++; $display("FAIL reset_out_p: got %h want 0", bus.out_p); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.row_a !== 2'd0 || bus.row_b !== 8'd0) begin failures++; $display("FAIL reset_row: got a=%h b=%h want 0/0", bus.row_a, bus.row_b); end
    rst_n = 1'b1;
  endtask

  // One full operation; hold = cycles out_ready stays low once the product is up.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int hold, input string name);
    logic [P_WIDTH-1:0] exp_p;
    exp_p = P_WIDTH'(a) * P_WIDTH'(b);
    @(negedge clk);
    bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1; bus.out_ready = (hold == 0);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL %s idle_in_ready: got %b want 1", name, bus.in_ready); end
    for (int k = 0; k < A_WIDTH / 2; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_a = 8'($urandom); bus.in_b = 8'($urandom);
      checks++;
      if (bus.row_a !== 2'((a >> (2 * k)) & 8'h3) || bus.row_b !== b || bus.busy !== 1'b1 ||
          bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL %s run%0d: got row_a=%h row_b=%h busy=%b in_ready=%b out_valid=%b want row_a=%h row_b=%h busy=1 in_ready=0 out_valid=0",
                 name, k, bus.row_a, bus.row_b, bus.busy, bus.in_ready, bus.out_valid, 2'((a >> (2 * k)) & 8'h3), b);
      end
    end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL %s out_valid: got %b want 1", name, bus.out_valid); end
    checks++; if (bus.out_p !== exp_p) begin failures++; $display("FAIL %s out_p: got %h want %h", name, bus.out_p, exp_p); end
    checks++; if (bus.row_a !== 2'd0 || bus.row_b !== 8'd0) begin failures++; $display("FAIL %s done_row: got a=%h b=%h want 0/0", name, bus.row_a, bus.row_b); end
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1; bus.in_a = 8'($urandom); bus.in_b = 8'($urandom);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_p !== exp_p || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL %s hold%0d: got out_valid=%b out_p=%h in_ready=%b busy=%b want 1 %h 0 1",
                 name, h, bus.out_valid, bus.out_p, bus.in_ready, bus.busy, exp_p);
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s release: got out_valid=%b in_ready=%b busy=%b want 0 1 0", name, bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_max();
    do_op(8'hFF, 8'hFF, 0, "max");
  endtask

  task automatic test_slices();
    do_op(8'hA5, 8'h3C, 0, "a5x3c");
  endtask

  task automatic test_zero();
    do_op(8'h00, 8'hB7, 0, "zero_a");
    do_op(8'h9C, 8'h00, 0, "zero_b");
  endtask

  task automatic test_backpressure();
    do_op(8'h12, 8'h34, 7, "backpressure");
  endtask

  task automatic test_reset_mid_run();
    bit seen_valid;
    @(negedge clk);
    bus.in_a = 8'h5A; bus.in_b = 8'hC3; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    checks++; if (bus.row_a !== 2'b01 || bus.busy !== 1'b1) begin failures++; $display("FAIL midrst_pre: got row_a=%h busy=%b want 1 1", bus.row_a, bus.busy); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_p !== '0 || bus.busy !== 1'b0 ||
        bus.row_a !== 2'd0 || bus.row_b !== 8'd0) begin
      failures++;
      $display("FAIL midrst_async: got in_ready=%b out_valid=%b out_p=%h busy=%b row_a=%h row_b=%h want 1 0 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_p, bus.busy, bus.row_a, bus.row_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen_valid = 1'b1;
    end
    checks++; if (seen_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_valid: got out_valid pulse=%b want 0", seen_valid); end
    do_op(8'h03, 8'h05, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [7:0]         a, b;
    logic [P_WIDTH-1:0] exp_p;
    int                 last_acc, waited;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    last_acc = -1;
    for (int n = 0; n < 200; n++) begin
      a = 8'($urandom); b = 8'($urandom);
      bus.in_a = a; bus.in_b = b;
      exp_p = P_WIDTH'(a) * P_WIDTH'(b);
      waited = 0;
      while (bus.in_ready !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
      if (waited >= 20) begin
        failures++; $display("FAIL b2b_accept_timeout: pair %0d never accepted", n); break;
      end
      if (last_acc >= 0) begin
        checks++;
        if (cyc - last_acc != 6) begin failures++; $display("FAIL b2b_spacing: pair %0d got %0d cycles want 6", n, cyc - last_acc); end
      end
      last_acc = cyc;
      @(negedge clk);
      waited = 0;
      while (bus.out_valid !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
      checks++;
      if (waited >= 20) begin
        failures++; $display("FAIL b2b_valid_timeout: pair %0d no out_valid", n); break;
      end else if (bus.out_p !== exp_p) begin
        failures++; $display("FAIL b2b_product: pair %0d a=%h b=%h got %h want %h", n, a, b, bus.out_p, exp_p);
      end
    end
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    cyc = 0; checks = 0; failures = 0;
    test_reset();
    test_max();
    test_slices();
    test_zero();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
